// File: rtl/mem_ctrl_pkg.sv
// Shared types for the data-side memory sequencer: access sizes, FSM states,
// transaction owner and the default MMIO window tag.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    DONE  = 2'b11
  } ctrl_state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LD  = 1'b1
  } owner_t;

  localparam logic [15:0] MMIO_HI_DEFAULT = 16'hFFFF;

  // Halfwords need an even address, words (and the unused size code) a
  // 4-byte aligned one; bytes are always aligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic mis;
    case (size)
      MEM_B:   mis = 1'b0;
      MEM_H:   mis = offset[0];
      default: mis = (offset != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/sub_word_align.sv
// Combinational lane logic: merges store data into a read word (RMW) and
// extracts/extends a byte or halfword lane from a loaded word.
module sub_word_align
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  output logic [31:0] merged,
  output logic [31:0] extracted
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Pick the addressed byte and halfword out of the word.
  always_comb begin
    byte_lane = 8'h00;
    case (offset)
      2'b00:   byte_lane = word[7:0];
      2'b01:   byte_lane = word[15:8];
      2'b10:   byte_lane = word[23:16];
      2'b11:   byte_lane = word[31:24];
      default: byte_lane = word[7:0];
    endcase
    if (offset[1]) begin
      half_lane = word[31:16];
    end else begin
      half_lane = word[15:0];
    end
  end

  // Replace only the addressed lane with the right-justified store data.
  always_comb begin
    merged = word;
    case (size)
      MEM_B: begin
        case (offset)
          2'b00:   merged[7:0]   = wdata[7:0];
          2'b01:   merged[15:8]  = wdata[7:0];
          2'b10:   merged[23:16] = wdata[7:0];
          2'b11:   merged[31:24] = wdata[7:0];
          default: merged        = word;
        endcase
      end
      MEM_H: begin
        if (offset[1]) begin
          merged[31:16] = wdata[15:0];
        end else begin
          merged[15:0] = wdata[15:0];
        end
      end
      default: merged = wdata;
    endcase
  end

  // Sign- or zero-extend the selected lane to a full word.
  always_comb begin
    extracted = word;
    case (size)
      MEM_B: begin
        if (is_unsigned) begin
          extracted = {24'h000000, byte_lane};
        end else begin
          extracted = {{24{byte_lane[7]}}, byte_lane};
        end
      end
      MEM_H: begin
        if (is_unsigned) begin
          extracted = {16'h0000, half_lane};
        end else begin
          extracted = {{16{half_lane[15]}}, half_lane};
        end
      end
      default: extracted = word;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-side memory port sequencer: arbitrates CPU load/store and loader word
// writes onto one word-wide port, doing RMW for sub-word stores and lane
// extraction for sub-word loads. All outputs are registered (Moore FSM).
module data_mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int          READ_LATENCY = 1,
  parameter logic [15:0] MMIO_HI      = MMIO_HI_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CpuReq,
  input  logic        CpuWe,
  input  logic [1:0]  CpuSize,
  input  logic        CpuUnsigned,
  input  logic [31:0] CpuAddr,
  input  logic [31:0] CpuWData,
  output logic [31:0] CpuRData,
  output logic        CpuDone,
  output logic        CpuMisalign,
  input  logic        LdReq,
  input  logic [31:0] LdAddr,
  input  logic [31:0] LdData,
  output logic        LdDone,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  output logic        MemWe,
  input  logic [31:0] MemRData
);

  localparam logic [1:0] LAT_M1 = 2'(READ_LATENCY - 1);

  ctrl_state_t state;
  owner_t      owner;
  mem_size_t   size_r;
  logic [1:0]  off_r;
  logic [31:0] wdata_r;
  logic        uns_r;
  logic        load_r;
  logic        mmio_r;
  logic [1:0]  cnt_r;

  logic        cpu_mmio_s;
  logic        cpu_mis_s;
  logic        cpu_rmw_path_s;
  logic [1:0]  lane_off_s;
  logic [31:0] merged_s;
  logic [31:0] extracted_s;

  assign cpu_mmio_s     = (CpuAddr[31:16] == MMIO_HI);
  assign cpu_mis_s      = is_misaligned(CpuSize, CpuAddr[1:0]);
  // Loads always read first; only non-MMIO sub-word stores need RMW.
  assign cpu_rmw_path_s = !CpuWe || (((CpuSize == MEM_B) || (CpuSize == MEM_H)) && !cpu_mmio_s);
  // MMIO words are treated as lane 0 for loads.
  assign lane_off_s     = mmio_r ? 2'b00 : off_r;

  sub_word_align u_align (
    .word        (MemRData),
    .wdata       (wdata_r),
    .size        (size_r),
    .offset      (lane_off_s),
    .is_unsigned (uns_r),
    .merged      (merged_s),
    .extracted   (extracted_s)
  );

  // Sequencer FSM: accept/arbitrate in IDLE, wait out read latency, single-cycle write, done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= OWN_CPU;
      size_r      <= MEM_W;
      off_r       <= 2'b00;
      wdata_r     <= 32'h0000_0000;
      uns_r       <= 1'b0;
      load_r      <= 1'b0;
      mmio_r      <= 1'b0;
      cnt_r       <= 2'b00;
      CpuRData    <= 32'h0000_0000;
      CpuDone     <= 1'b0;
      CpuMisalign <= 1'b0;
      LdDone      <= 1'b0;
      MemAddr     <= 32'h0000_0000;
      MemWData    <= 32'h0000_0000;
      MemWe       <= 1'b0;
    end else begin
      CpuDone     <= 1'b0;
      CpuMisalign <= 1'b0;
      LdDone      <= 1'b0;
      MemWe       <= 1'b0;
      case (state)
        IDLE: begin
          if (LdReq) begin
            owner    <= OWN_LD;
            load_r   <= 1'b0;
            mmio_r   <= 1'b0;
            MemAddr  <= {LdAddr[31:2], 2'b00};
            MemWData <= LdData;
            MemWe    <= 1'b1;
            state    <= WRITE;
          end else if (CpuReq) begin
            owner   <= OWN_CPU;
            size_r  <= mem_size_t'(CpuSize);
            off_r   <= CpuAddr[1:0];
            wdata_r <= CpuWData;
            uns_r   <= CpuUnsigned;
            load_r  <= !CpuWe;
            mmio_r  <= cpu_mmio_s;
            if (cpu_mis_s) begin
              CpuDone     <= 1'b1;
              CpuMisalign <= 1'b1;
              state       <= DONE;
            end else if (cpu_rmw_path_s) begin
              MemAddr <= {CpuAddr[31:2], 2'b00};
              cnt_r   <= 2'b00;
              state   <= READ;
            end else begin
              MemAddr  <= {CpuAddr[31:2], 2'b00};
              MemWData <= CpuWData;
              MemWe    <= 1'b1;
              state    <= WRITE;
            end
          end else begin
            state <= IDLE;
          end
        end
        READ: begin
          if (cnt_r == LAT_M1) begin
            if (load_r) begin
              CpuRData <= extracted_s;
              CpuDone  <= 1'b1;
              state    <= DONE;
            end else begin
              MemWData <= merged_s;
              MemWe    <= 1'b1;
              state    <= WRITE;
            end
          end else begin
            cnt_r <= cnt_r + 2'd1;
          end
        end
        WRITE: begin
          if (owner == OWN_LD) begin
            LdDone <= 1'b1;
          end else begin
            CpuDone <= 1'b1;
          end
          state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed scoreboard bench for data_mem_ctrl, run on two instances
// (READ_LATENCY 1 and 3), each with its own negedge-clocked memory model.
module tb_data_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        cpu_req [2];
  logic        cpu_we [2];
  logic [1:0]  cpu_size [2];
  logic        cpu_uns [2];
  logic [31:0] cpu_addr [2];
  logic [31:0] cpu_wdata [2];
  logic [31:0] cpu_rdata [2];
  logic        cpu_done [2];
  logic        cpu_mis [2];
  logic        ld_req [2];
  logic [31:0] ld_addr [2];
  logic [31:0] ld_data [2];
  logic        ld_done [2];
  logic [31:0] mem_addr [2];
  logic [31:0] mem_wdata [2];
  logic        mem_we [2];
  logic [31:0] mem_rdata [2];

  logic [31:0] mem0 [64];
  logic [31:0] mem1 [64];
  logic [31:0] pipe0;
  logic [31:0] pipe1 [3];

  typedef struct {
    string       tag;
    logic        is_ld;
    logic [31:0] rdata;
    logic        mis;
    int          lat;
  } exp_t;

  exp_t sb_q [$];
  int   n_assert = 0;
  int   n_fail   = 0;

  data_mem_ctrl #(.READ_LATENCY(1), .MMIO_HI(16'hFFFF)) dut_l1 (
    .clk(clk), .reset(reset),
    .CpuReq(cpu_req[0]), .CpuWe(cpu_we[0]), .CpuSize(cpu_size[0]), .CpuUnsigned(cpu_uns[0]),
    .CpuAddr(cpu_addr[0]), .CpuWData(cpu_wdata[0]), .CpuRData(cpu_rdata[0]),
    .CpuDone(cpu_done[0]), .CpuMisalign(cpu_mis[0]),
    .LdReq(ld_req[0]), .LdAddr(ld_addr[0]), .LdData(ld_data[0]), .LdDone(ld_done[0]),
    .MemAddr(mem_addr[0]), .MemWData(mem_wdata[0]), .MemWe(mem_we[0]), .MemRData(mem_rdata[0])
  );

  data_mem_ctrl #(.READ_LATENCY(3), .MMIO_HI(16'hFFFF)) dut_l3 (
    .clk(clk), .reset(reset),
    .CpuReq(cpu_req[1]), .CpuWe(cpu_we[1]), .CpuSize(cpu_size[1]), .CpuUnsigned(cpu_uns[1]),
    .CpuAddr(cpu_addr[1]), .CpuWData(cpu_wdata[1]), .CpuRData(cpu_rdata[1]),
    .CpuDone(cpu_done[1]), .CpuMisalign(cpu_mis[1]),
    .LdReq(ld_req[1]), .LdAddr(ld_addr[1]), .LdData(ld_data[1]), .LdDone(ld_done[1]),
    .MemAddr(mem_addr[1]), .MemWData(mem_wdata[1]), .MemWe(mem_we[1]), .MemRData(mem_rdata[1])
  );

  // Memory for the latency-1 instance: write and read on the falling edge.
  always @(negedge clk) begin
    if (mem_we[0]) mem0[mem_addr[0][7:2]] <= mem_wdata[0];
    pipe0 <= mem0[mem_addr[0][7:2]];
  end

  // Memory for the latency-3 instance: three falling-edge read stages.
  always @(negedge clk) begin
    if (mem_we[1]) mem1[mem_addr[1][7:2]] <= mem_wdata[1];
    pipe1[0] <= mem1[mem_addr[1][7:2]];
    pipe1[1] <= pipe1[0];
    pipe1[2] <= pipe1[1];
  end

  assign mem_rdata[0] = pipe0;
  assign mem_rdata[1] = pipe1[2];

  // Hard stop if something hangs despite the bounded waits.
  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, observed no end, expected $finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input int lane, input logic [31:0] a);
    return (lane == 0) ? mem0[a[7:2]] : mem1[a[7:2]];
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One CPU transaction: push expectation, hold request until done, pop and compare.
  task automatic cpu_op(input int lane, input string tag, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_mis, input int exp_lat,
                        input int exp_we_at, input logic [31:0] exp_wd);
    exp_t e;
    int got_at, we_at, we_cnt;
    logic [31:0] wd_obs, wa_obs;
    e.tag = tag; e.is_ld = 1'b0; e.rdata = exp_rd; e.mis = exp_mis; e.lat = exp_lat;
    sb_q.push_back(e);
    @(posedge clk); #1;
    cpu_we[lane] = we; cpu_size[lane] = size; cpu_uns[lane] = uns;
    cpu_addr[lane] = addr; cpu_wdata[lane] = wdata; cpu_req[lane] = 1'b1;
    got_at = -1; we_at = -1; we_cnt = 0; wd_obs = 32'h0; wa_obs = 32'h0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (mem_we[lane]) begin
        we_cnt++; we_at = i; wd_obs = mem_wdata[lane]; wa_obs = mem_addr[lane];
      end
      if (cpu_done[lane]) begin
        got_at = i;
        break;
      end
    end
    e = sb_q.pop_front();
    check({e.tag, " latency"}, got_at, e.lat);
    check({e.tag, " misalign"}, cpu_mis[lane], e.mis);
    if (!we && !exp_mis) check({e.tag, " rdata"}, cpu_rdata[lane], e.rdata);
    check({e.tag, " write count"}, we_cnt, (exp_we_at < 0) ? 0 : 1);
    if (exp_we_at >= 0) begin
      check({e.tag, " write cycle"}, we_at, exp_we_at);
      check({e.tag, " write data"}, wd_obs, exp_wd);
      check({e.tag, " write addr"}, wa_obs, {addr[31:2], 2'b00});
    end
    @(posedge clk); #1;
    cpu_req[lane] = 1'b0;
  endtask

  // Loader and CPU raise requests in the same cycle: loader first, CPU next.
  task automatic arb_test(input int lane);
    exp_t e;
    int L, ld_at, cpu_at, extra, i;
    L = (lane == 0) ? 1 : 3;
    e.tag = "arb ld"; e.is_ld = 1'b1; e.rdata = 32'h0; e.mis = 1'b0; e.lat = 2;
    sb_q.push_back(e);
    e.tag = "arb cpu"; e.is_ld = 1'b0; e.rdata = 32'h1234_5678; e.mis = 1'b0; e.lat = L + 4;
    sb_q.push_back(e);
    @(posedge clk); #1;
    ld_addr[lane] = 32'h0000_0020; ld_data[lane] = 32'h1234_5678; ld_req[lane] = 1'b1;
    cpu_we[lane] = 1'b0; cpu_size[lane] = MEM_W; cpu_uns[lane] = 1'b0;
    cpu_addr[lane] = 32'h0000_0020; cpu_req[lane] = 1'b1;
    ld_at = -1; cpu_at = -1; extra = 0; i = 0;
    while (i < 40 && ld_at < 0) begin
      @(negedge clk);
      if (cpu_done[lane]) cpu_at = i;
      if (ld_done[lane]) ld_at = i;
      i++;
    end
    e = sb_q.pop_front();
    check({e.tag, " latency"}, ld_at, e.lat);
    check("arb cpu stalled during loader", cpu_at, -1);
    @(posedge clk); #1;
    ld_req[lane] = 1'b0;
    while (i < 80 && cpu_at < 0) begin
      @(negedge clk);
      if (ld_done[lane]) extra++;
      if (cpu_done[lane]) cpu_at = i;
      i++;
    end
    e = sb_q.pop_front();
    check({e.tag, " latency"}, cpu_at, e.lat);
    check({e.tag, " rdata"}, cpu_rdata[lane], e.rdata);
    @(posedge clk); #1;
    cpu_req[lane] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (cpu_done[lane] || ld_done[lane]) extra++;
    end
    check("arb no double serve", extra, 0);
    check("arb loader word", mem_word(lane, 32'h20), 32'h1234_5678);
  endtask

  // Reset in READ of a byte store and in WRITE of a loader write.
  task automatic reset_test(input int lane);
    int pulses;
    pulses = 0;
    @(posedge clk); #1;
    cpu_we[lane] = 1'b1; cpu_size[lane] = MEM_B; cpu_uns[lane] = 1'b0;
    cpu_addr[lane] = 32'h0000_0010; cpu_wdata[lane] = 32'h0000_0077; cpu_req[lane] = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1; cpu_req[lane] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst in READ outputs zero",
          {cpu_rdata[lane], mem_addr[lane], mem_wdata[lane], cpu_done[lane], cpu_mis[lane], ld_done[lane], mem_we[lane]},
          128'h0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (cpu_done[lane] || ld_done[lane] || mem_we[lane]) pulses++;
    end
    check("rst in READ no activity", pulses, 0);
    check("rst in READ memory unchanged", mem_word(lane, 32'h10), 32'h8001_5AEF);

    @(posedge clk); #1;
    ld_addr[lane] = 32'h0000_0024; ld_data[lane] = 32'hCAFE_F00D; ld_req[lane] = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1; ld_req[lane] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst in WRITE outputs zero",
          {cpu_rdata[lane], mem_addr[lane], mem_wdata[lane], cpu_done[lane], cpu_mis[lane], ld_done[lane], mem_we[lane]},
          128'h0);
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (cpu_done[lane] || ld_done[lane] || mem_we[lane]) pulses++;
    end
    check("rst in WRITE no done", pulses, 0);
    check("rst in WRITE committed", mem_word(lane, 32'h24), 32'hCAFE_F00D);
  endtask

  task automatic run_suite(input int lane);
    int L;
    L = (lane == 0) ? 1 : 3;
    // word store then word load
    cpu_op(lane, "SW 10", 1'b1, MEM_W, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 1, 32'hDEAD_BEEF);
    cpu_op(lane, "LW 10", 1'b0, MEM_W, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, L + 1, -1, 32'h0);
    // byte store RMW and byte loads
    cpu_op(lane, "SB 11", 1'b1, MEM_B, 1'b0, 32'h11, 32'h0000_005A, 32'h0, 1'b0, L + 2, L + 1, 32'hDEAD_5AEF);
    cpu_op(lane, "LB 11", 1'b0, MEM_B, 1'b0, 32'h11, 32'h0, 32'h0000_005A, 1'b0, L + 1, -1, 32'h0);
    cpu_op(lane, "LBU 13", 1'b0, MEM_B, 1'b1, 32'h13, 32'h0, 32'h0000_00DE, 1'b0, L + 1, -1, 32'h0);
    cpu_op(lane, "LB 13", 1'b0, MEM_B, 1'b0, 32'h13, 32'h0, 32'hFFFF_FFDE, 1'b0, L + 1, -1, 32'h0);
    // half store RMW and half loads
    cpu_op(lane, "SH 12", 1'b1, MEM_H, 1'b0, 32'h12, 32'h0000_8001, 32'h0, 1'b0, L + 2, L + 1, 32'h8001_5AEF);
    check("rdata held across store", cpu_rdata[lane], 32'hFFFF_FFDE);
    cpu_op(lane, "LH 12", 1'b0, MEM_H, 1'b0, 32'h12, 32'h0, 32'hFFFF_8001, 1'b0, L + 1, -1, 32'h0);
    cpu_op(lane, "LHU 12", 1'b0, MEM_H, 1'b1, 32'h12, 32'h0, 32'h0000_8001, 1'b0, L + 1, -1, 32'h0);
    cpu_op(lane, "LH 10", 1'b0, MEM_H, 1'b0, 32'h10, 32'h0, 32'h0000_5AEF, 1'b0, L + 1, -1, 32'h0);
    // misaligned requests
    cpu_op(lane, "LH 11 mis", 1'b0, MEM_H, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1, 1, -1, 32'h0);
    cpu_op(lane, "LW 12 mis", 1'b0, MEM_W, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1, 1, -1, 32'h0);
    cpu_op(lane, "SW 13 mis", 1'b1, MEM_W, 1'b0, 32'h13, 32'h1111_1111, 32'h0, 1'b1, 1, -1, 32'h0);
    check("misaligned memory unchanged", mem_word(lane, 32'h10), 32'h8001_5AEF);
    // MMIO: byte store written unshifted as a full word, loads use lane 0
    cpu_op(lane, "SB mmio", 1'b1, MEM_B, 1'b0, 32'hFFFF_0005, 32'h0000_00A5, 32'h0, 1'b0, 2, 1, 32'h0000_00A5);
    cpu_op(lane, "LB mmio", 1'b0, MEM_B, 1'b0, 32'hFFFF_0007, 32'h0, 32'hFFFF_FFA5, 1'b0, L + 1, -1, 32'h0);
    cpu_op(lane, "LBU mmio", 1'b0, MEM_B, 1'b1, 32'hFFFF_0007, 32'h0, 32'h0000_00A5, 1'b0, L + 1, -1, 32'h0);
    arb_test(lane);
    reset_test(lane);
    // back in IDLE and serving after the aborted transactions
    cpu_op(lane, "LW 24 after reset", 1'b0, MEM_W, 1'b0, 32'h24, 32'h0, 32'hCAFE_F00D, 1'b0, L + 1, -1, 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    for (int l = 0; l < 2; l++) begin
      cpu_req[l] = 1'b0; cpu_we[l] = 1'b0; cpu_size[l] = MEM_W; cpu_uns[l] = 1'b0;
      cpu_addr[l] = 32'h0; cpu_wdata[l] = 32'h0;
      ld_req[l] = 1'b0; ld_addr[l] = 32'h0; ld_data[l] = 32'h0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int l = 0; l < 2; l++) begin
      check("reset outputs zero",
            {cpu_rdata[l], mem_addr[l], mem_wdata[l], cpu_done[l], cpu_mis[l], ld_done[l], mem_we[l]},
            128'h0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    run_suite(0);
    run_suite(1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
